ram_master: RTL and testbench

RAM_MASTER -- requirements
Module: ram_master

---
 rtl/ram_master.sv | 122 ++++++++++++
 tb/tb_ram_master.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_master.sv
// ram_master: burst RAM master (write/read bursts, 2-credit read buffer); RAM_MASTER_WRAP_ERR_EN rejects wrapping bursts
module ram_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [ADDR_W-1:0] cmd_len_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              ram_cs_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              done_o,
  output logic              err_o
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  localparam logic [ADDR_W-1:0] one_a = 1;
  localparam logic [ADDR_W:0] one_r = 1;
  state_t state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0] rem;
  logic [1:0] credits, cnt;
  logic cap, wptr, rptr, pop, issue, bad;
  logic [DATA_W-1:0] fifo [2];
  assign cmd_ready_o = state == IDLE;
  assign wr_ready_o = state == WRITE && rem != '0;
  assign rd_valid_o = cnt != 2'd0;
  assign rd_data_o = fifo[rptr];
  assign pop = rd_valid_o & rd_ready_i;
  assign issue = (state == IDLE && cmd_valid_i && !cmd_we_i && !bad) ||
                 (state == READ && (credits != 2'd0 || pop));
`ifdef RAM_MASTER_WRAP_ERR_EN
  assign bad = ({1'b0, cmd_addr_i} + {1'b0, cmd_len_i}) > {1'b0, {ADDR_W{1'b1}}};
`else
  assign bad = 1'b0;
`endif
  // Read-return storage; occupancy and pointers live in the control block
  always_ff @(posedge clk_i)
    if (cap) fifo[wptr] <= ram_data_i;
  // Burst FSM with registered RAM bus, read credits and buffer bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      credits <= 2'd2;
      cnt <= 2'd0;
      cap <= 1'b0;
      wptr <= 1'b0;
      rptr <= 1'b0;
      ram_cs_o <= 1'b0;
      ram_we_o <= 1'b0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
      done_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      ram_cs_o <= 1'b0;
      ram_we_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      cap <= ram_cs_o & ~ram_we_o;
      credits <= credits - {1'b0, issue} + {1'b0, pop};
      cnt <= cnt + {1'b0, cap} - {1'b0, pop};
      wptr <= wptr ^ cap;
      rptr <= rptr ^ pop;
      case (state)
        IDLE:
          if (cmd_valid_i) begin
            err_o <= bad;
            if (!bad && cmd_we_i) begin
              state <= WRITE;
              addr <= cmd_addr_i;
              rem <= {1'b0, cmd_len_i} + one_r;
            end else if (!bad) begin
              state <= cmd_len_i == '0 ? DRAIN : READ;
              ram_cs_o <= 1'b1;
              ram_addr_o <= cmd_addr_i;
              addr <= cmd_addr_i + one_a;
              rem <= {1'b0, cmd_len_i};
            end
          end
        WRITE:
          if (rem == '0) begin
            state <= IDLE;
            done_o <= 1'b1;
          end else if (wr_valid_i) begin
            ram_cs_o <= 1'b1;
            ram_we_o <= 1'b1;
            ram_addr_o <= addr;
            ram_data_o <= wr_data_i;
            addr <= addr + one_a;
            rem <= rem - one_r;
          end
        READ:
          if (issue) begin
            ram_cs_o <= 1'b1;
            ram_addr_o <= addr;
            addr <= addr + one_a;
            rem <= rem - one_r;
            if (rem == one_r) state <= DRAIN;
          end
        DRAIN:
          if (pop && credits == 2'd1) begin
            state <= IDLE;
            done_o <= 1'b1;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: randomized scoreboard bench for ram_master against an array-based memory model
module tb_ram_master;
  localparam int AW = 8, DW = 32;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_we = 0, wr_valid = 0, rd_ready = 1;
  logic [AW-1:0] cmd_addr = 0, cmd_len = 0;
  logic [DW-1:0] wr_data = 0;
  logic cmd_ready, wr_ready, rd_valid, ram_cs, ram_we, done, err;
  logic [DW-1:0] rd_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  logic [AW+DW-1:0] wq[$];
  logic [DW-1:0] rq[$];
  int tests = 0, fails = 0, cyc = 0, last_wr = -1, last_rd = -1, hs = 0, done_n = 0, out_n = 0;
  logic prev_hold = 0;
  logic [DW-1:0] prev_data = 0;

  ram_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .ram_cs_o(ram_cs), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_data_o(ram_wdata), .ram_data_i(ram_rdata),
    .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous RAM: read data valid the cycle after the access
  always @(posedge clk) begin
    if (cyc == 0)
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 + i;
    else if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops scoreboard entries whenever the DUT strobes RAM writes or hands out read beats
  always @(negedge clk) begin
    if (rst) begin
      out_n = 0;
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk("rd_hold_valid", rd_valid, 1);
        chk("rd_hold_data", rd_data, prev_data);
      end
      if (ram_cs && ram_we) begin
        chk("write_expected", wq.size() != 0, 1);
        if (wq.size() != 0) chk("ram_write", {ram_addr, ram_wdata}, wq.pop_front());
        last_wr = cyc;
      end
      if (ram_cs && !ram_we) begin
        out_n++;
        chk("outstanding_le_2", out_n <= 2, 1);
      end
      if (rd_valid && rd_ready) begin
        chk("read_expected", rq.size() != 0, 1);
        if (rq.size() != 0) chk("rd_data", rd_data, rq.pop_front());
        hs++;
        out_n--;
        last_rd = cyc;
      end
      if (done) done_n++;
      prev_hold = rd_valid && !rd_ready;
      prev_data = rd_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [AW-1:0] l, output int c);
    c = cyc;
    cmd_valid = 1;
    cmd_we = we;
    cmd_addr = a;
    cmd_len = l;
    @(negedge clk);
    chk("cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] l, input bit gap, input int base);
    int c, n = 0, t = 0, d0 = done_n;
    bit got = 0;
    send(1, a, l, c);
    while (n <= int'(l) && t < 1000) begin
      wr_valid = gap ? t[0] : 1'b1;
      wr_data = base >= 0 ? DW'(base + n) : $urandom;
      @(negedge clk);
      if (wr_valid && wr_ready) begin
        wq.push_back({a + AW'(n), wr_data});
        ref_mem[a + AW'(n)] = wr_data;
        n++;
      end
      t++;
      tick();
    end
    wr_valid = 0;
    chk("wr_beats", n, int'(l) + 1);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        chk("wr_done_time", cyc, last_wr + 1);
        chk("wr_done_idle", cmd_ready, 1);
      end
    end
    tick();
    chk("wr_done_seen", got, 1);
    chk("wr_done_count", done_n - d0, 1);
    chk("wr_queue_empty", wq.size(), 0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] l, input int stall);
    int c, first = -1, h0 = hs, sc = 0, d0 = done_n;
    bit got = 0;
    for (int i = 0; i <= int'(l); i++) rq.push_back(ref_mem[a + AW'(i)]);
    rd_ready = 1;
    send(0, a, l, c);
    for (int t = 0; t < 2000 && !got; t++) begin
      @(negedge clk);
      if (rd_valid && first < 0) first = cyc;
      if (done) begin
        got = 1;
        chk("rd_done_time", cyc, last_rd + 1);
        chk("rd_done_idle", cmd_ready, 1);
      end
      tick();
      rd_ready = (stall > 0 && hs - h0 >= 1 && sc < stall) ? 1'b0 : 1'b1;
      if (!rd_ready) sc++;
    end
    rd_ready = 1;
    chk("rd_first_valid", first, c + 3);
    chk("rd_done_seen", got, 1);
    chk("rd_done_count", done_n - d0, 1);
    chk("rd_beats", hs - h0, int'(l) + 1);
    chk("rd_queue_empty", rq.size(), 0);
  endtask

`ifdef RAM_MASTER_WRAP_ERR_EN
  task automatic do_err(input logic [AW-1:0] a, input logic [AW-1:0] l);
    int c, d0 = done_n;
    send(1, a, l, c);
    @(negedge clk);
    chk("err_pulse", err, 1);
    chk("err_idle", cmd_ready, 1);
    tick();
    @(negedge clk);
    chk("err_one_cycle", err, 0);
    repeat (4) tick();
    chk("err_no_done", done_n - d0, 0);
  endtask
`endif

  task automatic do_reset_mid();
    int c, h0 = hs, t = 0, d0;
    for (int i = 0; i < 16; i++) rq.push_back(ref_mem[8'h40 + AW'(i)]);
    send(0, 8'h40, 8'd15, c);
    while (hs - h0 < 3 && t < 100) begin
      tick();
      t++;
    end
    chk("rst_reached_beat4", hs - h0 >= 3, 1);
    rst = 1;
    rq.delete();
    d0 = done_n;
    tick();
    rst = 0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_outputs", {ram_cs, ram_we, ram_addr, ram_wdata, rd_valid, wr_ready, done, err}, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      chk("rst_no_stale_rd", rd_valid, 0);
    end
    tick();
    chk("rst_no_done", done_n - d0, 0);
  endtask

  initial begin
    logic [AW-1:0] a, l;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 + i;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_outputs", {ram_cs, ram_we, ram_addr, ram_wdata, rd_valid, wr_ready, done, err}, 0);
    tick();
    rst = 0;
    tick();
    do_write(8'h10, 8'd3, 0, 32'hA0);
    do_read(8'h10, 8'd3, 0);
    do_read(8'h10, 8'd7, 5);
`ifdef RAM_MASTER_WRAP_ERR_EN
    do_err(8'hFE, 8'd3);
`else
    do_write(8'hFE, 8'd3, 0, -1);
    do_read(8'hFE, 8'd3, 0);
`endif
    do_write(8'h30, 8'd5, 1, -1);
    do_read(8'h30, 8'd5, 2);
    do_write(8'hFF, 8'd0, 0, -1);
    do_read(8'h00, 8'd0, 0);
    wr_valid = 1;
    wr_data = 32'hDEAD_BEEF;
    repeat (3) tick();
    wr_valid = 0;
    do_reset_mid();
    for (int r = 0; r < 24; r++) begin
      a = AW'($urandom);
      l = AW'($urandom_range(0, 9));
`ifdef RAM_MASTER_WRAP_ERR_EN
      if (int'(a) + int'(l) > 255) a = AW'(255 - int'(l));
`endif
      if ($urandom_range(0, 1) == 1) do_write(a, l, 1'($urandom_range(0, 1)), -1);
      else do_read(a, l, $urandom_range(0, 4));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
